way_fill_writer: RTL and testbench
==================================

WAY_FILL_WRITER -- requirements
Module: way_fill_writer

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways; only 4 is supported.
REQ-002 SHALL have parameter LINE_SIZE_BYTES, default 4, line data width is LINE_SIZE_BYTES*8 (=32).
REQ-003 SHALL have parameters LRU_BITS=1, VALID_BITS=1, DIRTY_BITS=1, TAG_BITS=18, INDEX_BITS=12; entry width E=VALID+LRU+DIRTY+TAG+data (=53).
REQ-004 SHALL pack each entry MSB-first as {valid, lru, dirty, tag, data}: valid[52], lru[51], dirty[50], tag[49:32], data[31:0].
REQ-005 i_clk  input  1  single clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_req_valid  input  1  fill request valid.
REQ-008 o_req_ready  output  1  high only in IDLE.
REQ-009 i_index  input  INDEX_BITS  set index of fill.
REQ-010 i_tag  input  TAG_BITS  tag of fill line.
REQ-011 i_data  input  LINE_SIZE_BYTES*8  fill line data.
REQ-012 i_dirty  input  1  dirty bit to store with fill.
REQ-013 i_sel  input  4  one-hot forced way; 4'b0000 = choose victim.
REQ-014 i_ways  input  E x WAYS  unpacked array [0:WAYS-1], current entries of addressed set, valid the cycle after accept.
REQ-015 o_wb_valid / i_wb_ready  output/input  1/1  dirty-victim writeback handshake.
REQ-016 o_wb_index, o_wb_tag, o_wb_data  outputs  INDEX_BITS, TAG_BITS, 32  victim writeback payload.
REQ-017 o_we  output  4  one-hot way write strobe.
REQ-018 o_windex, o_wdata  outputs  INDEX_BITS, E  write address and packed entry.
REQ-019 o_done  output  1  one-cycle pulse, fill complete.

Function
REQ-020 SHALL implement FSM IDLE -> SELECT -> (WRITEBACK) -> WRITE -> IDLE.
REQ-021 IDLE: request accepted when i_req_valid && o_req_ready; index, tag, data, dirty, sel registered; next state SELECT.
REQ-022 SELECT (exactly one cycle): victim way chosen from i_ways and registered; victim entry tag/data copied to writeback registers.
REQ-023 Victim rule: i_sel one-hot -> that way; else lowest-index way with valid=0; else lowest-index way with lru=0; else way 0.
REQ-024 i_sel non-zero but not one-hot SHALL be treated as 4'b0000.
REQ-025 From SELECT: victim valid=1 and dirty=1 -> WRITEBACK; otherwise -> WRITE.
REQ-026 WRITEBACK: o_wb_valid=1, payload stable until i_wb_ready=1; on handshake cycle -> WRITE.
REQ-027 WRITE (exactly one cycle): o_we = victim one-hot, o_windex = registered index, o_wdata = {1'b1, 1'b1, dirty, tag, data}; o_done=1; next IDLE.
REQ-028 o_we, o_done, o_wb_valid SHALL be 0 in every state other than their own.
REQ-029 Latency, no writeback: accept at edge N, o_we/o_done high during cycle N+2; o_req_ready high again at N+3.
REQ-030 Latency, writeback: o_wb_valid rises in cycle N+2; o_we asserted the cycle after the i_wb_ready handshake.
REQ-031 i_req_valid while busy SHALL be ignored (no queueing); request inputs may change after accept.
REQ-032 i_ways changes outside SELECT SHALL have no effect.

Reset
REQ-033 i_rst_n low SHALL asynchronously force IDLE; o_req_ready=1 after release, o_we=0, o_done=0, o_wb_valid=0, all payload registers 0.
REQ-034 Reset mid-WRITEBACK or mid-WRITE SHALL abandon the fill with no o_we pulse after release.

Verification
REQ-035 All ways valid, lru={1,0,1,1}, i_sel=0, clean -> o_we=4'b0010, o_wdata[52:50]=3'b11x, no o_wb_valid.
REQ-036 Way 2 invalid, others valid/dirty -> o_we=4'b0100 at N+2, no writeback.
REQ-037 i_sel=4'b1000, way3 valid+dirty tag 18'h3ABCD data 32'hDEADBEEF -> o_wb_tag=18'h3ABCD, o_wb_data=32'hDEADBEEF; i_wb_ready held low 5 cycles, payload stable; o_we=4'b1000 the cycle after ready.
REQ-038 i_sel=4'b0110 with way0 invalid -> treated as victim select, o_we=4'b0001.
REQ-039 Second i_req_valid during WRITEBACK -> ignored, exactly one o_done.
REQ-040 i_rst_n asserted in WRITEBACK -> o_wb_valid=0 immediately, no o_we, o_req_ready=1 after release.

Source files
------------

// File: rtl/way_fill_writer_if.sv
// Fill-request, victim writeback and way-write signals of way_fill_writer.
// The slave modport is the fill writer; the master modport is the requester/cache side.
interface way_fill_writer_if #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned INDEX_BITS = 12,
    parameter int unsigned TAG_BITS   = 18,
    parameter int unsigned DATA_BITS  = 32,
    parameter int unsigned ENTRY_BITS = 53
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic [INDEX_BITS-1:0] i_index;
    logic [TAG_BITS-1:0]   i_tag;
    logic [DATA_BITS-1:0]  i_data;
    logic                  i_dirty;
    logic [WAYS-1:0]       i_sel;
    logic [ENTRY_BITS-1:0] i_ways [0:WAYS-1];

    logic                  o_wb_valid;
    logic                  i_wb_ready;
    logic [INDEX_BITS-1:0] o_wb_index;
    logic [TAG_BITS-1:0]   o_wb_tag;
    logic [DATA_BITS-1:0]  o_wb_data;

    logic [WAYS-1:0]       o_we;
    logic [INDEX_BITS-1:0] o_windex;
    logic [ENTRY_BITS-1:0] o_wdata;
    logic                  o_done;

    modport master (
        output i_req_valid, i_index, i_tag, i_data, i_dirty, i_sel, i_ways, i_wb_ready,
        input  o_req_ready, o_wb_valid, o_wb_index, o_wb_tag, o_wb_data,
        input  o_we, o_windex, o_wdata, o_done
    );

    modport slave (
        input  i_req_valid, i_index, i_tag, i_data, i_dirty, i_sel, i_ways, i_wb_ready,
        output o_req_ready, o_wb_valid, o_wb_index, o_wb_tag, o_wb_data,
        output o_we, o_windex, o_wdata, o_done
    );
endinterface

// File: rtl/way_fill_writer.sv
// Cache line fill writer: picks a victim way, writes back a dirty victim, then
// writes the new line into the chosen way and pulses done.
module way_fill_writer #(
    parameter int unsigned WAYS            = 4,
    parameter int unsigned LINE_SIZE_BYTES = 4,
    parameter int unsigned LRU_BITS        = 1,
    parameter int unsigned VALID_BITS      = 1,
    parameter int unsigned DIRTY_BITS      = 1,
    parameter int unsigned TAG_BITS        = 18,
    parameter int unsigned INDEX_BITS      = 12
) (
    input logic              i_clk,
    input logic              i_rst_n,
    way_fill_writer_if.slave bus
);
    localparam int unsigned DATA_W    = LINE_SIZE_BYTES * 8;
    localparam int unsigned E         = VALID_BITS + LRU_BITS + DIRTY_BITS + TAG_BITS + DATA_W;
    localparam int unsigned VALID_POS = E - 1;
    localparam int unsigned LRU_POS   = VALID_POS - VALID_BITS;
    localparam int unsigned DIRTY_POS = LRU_POS - LRU_BITS;
    localparam logic [WAYS-1:0] ONE   = WAYS'(1);

    typedef enum logic [1:0] {StIdle, StSelect, StWriteback, StWrite} state_e;

    state_e state_q, state_d;

    logic [INDEX_BITS-1:0] index_q;
    logic [TAG_BITS-1:0]   tag_q, wb_tag_q;
    logic [DATA_W-1:0]     data_q, wb_data_q;
    logic                  dirty_q;
    logic [WAYS-1:0]       sel_q, victim_q, victim_d;

    logic                  sel_onehot, found;
    logic                  vic_valid, vic_dirty;
    logic [TAG_BITS-1:0]   vic_tag;
    logic [DATA_W-1:0]     vic_data;

    // Victim choice: forced one-hot way, else first invalid, else first lru=0, else way 0.
    always_comb begin
        sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - ONE)) == '0);
        victim_d   = '0;
        found      = 1'b0;
        if (sel_onehot) begin
            victim_d = sel_q;
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (!found && !bus.i_ways[i][VALID_POS]) begin
                    victim_d[i] = 1'b1;
                    found       = 1'b1;
                end
            end
            for (int i = 0; i < WAYS; i++) begin
                if (!found && !bus.i_ways[i][LRU_POS]) begin
                    victim_d[i] = 1'b1;
                    found       = 1'b1;
                end
            end
            if (!found) begin
                victim_d[0] = 1'b1;
            end
        end
    end

    always_comb begin
        vic_valid = 1'b0;
        vic_dirty = 1'b0;
        vic_tag   = '0;
        vic_data  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (victim_d[i]) begin
                vic_valid = bus.i_ways[i][VALID_POS];
                vic_dirty = bus.i_ways[i][DIRTY_POS];
                vic_tag   = bus.i_ways[i][DATA_W +: TAG_BITS];
                vic_data  = bus.i_ways[i][DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (bus.i_req_valid) state_d = StSelect;
            StSelect:    state_d = (vic_valid && vic_dirty) ? StWriteback : StWrite;
            StWriteback: if (bus.i_wb_ready) state_d = StWrite;
            StWrite:     state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            index_q   <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            dirty_q   <= 1'b0;
            sel_q     <= '0;
            victim_q  <= '0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
        end else if (state_q == StIdle && bus.i_req_valid) begin
            index_q <= bus.i_index;
            tag_q   <= bus.i_tag;
            data_q  <= bus.i_data;
            dirty_q <= bus.i_dirty;
            sel_q   <= bus.i_sel;
        end else if (state_q == StSelect) begin
            victim_q  <= victim_d;
            wb_tag_q  <= vic_tag;
            wb_data_q <= vic_data;
        end
    end

    always_comb begin
        bus.o_req_ready = (state_q == StIdle);
        bus.o_wb_valid  = (state_q == StWriteback);
        bus.o_wb_index  = index_q;
        bus.o_wb_tag    = wb_tag_q;
        bus.o_wb_data   = wb_data_q;
        bus.o_windex    = index_q;
        bus.o_we        = '0;
        bus.o_wdata     = '0;
        bus.o_done      = 1'b0;
        if (state_q == StWrite) begin
            bus.o_we    = victim_q;
            bus.o_wdata = {1'b1, 1'b1, dirty_q, tag_q, data_q};
            bus.o_done  = 1'b1;
        end
    end
endmodule

// File: tb/tb_way_fill_writer.sv
// Self-checking bench for way_fill_writer: spec vectors, reset corner cases and
// randomized fills checked against a rule-level victim model.
module tb_way_fill_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    way_fill_writer_if #(
        .WAYS(4), .INDEX_BITS(12), .TAG_BITS(18), .DATA_BITS(32), .ENTRY_BITS(53)
    ) bus ();

    way_fill_writer #(
        .WAYS(4), .LINE_SIZE_BYTES(4), .LRU_BITS(1), .VALID_BITS(1), .DIRTY_BITS(1),
        .TAG_BITS(18), .INDEX_BITS(12)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    always @(posedge clk) if (bus.o_done) done_cnt <= done_cnt + 1;

    typedef struct {
        string            name;
        logic [3:0]       sel;
        logic [3:0][52:0] ways;
        logic             dirty;
        logic [3:0]       exp_we;
        bit               exp_wb;
        int               delay;
        bit               busy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [52:0] mk(input bit v, input bit l, input bit d,
                                       input logic [17:0] t, input logic [31:0] dat);
        return {v, l, d, t, dat};
    endfunction

    // Reference victim choice straight from the replacement rules.
    function automatic int model_victim(input logic [3:0] sel, input logic [3:0][52:0] w);
        if ($countones(sel) == 1) begin
            for (int i = 0; i < 4; i++) if (sel[i]) return i;
        end
        for (int i = 0; i < 4; i++) if (!w[i][52]) return i;
        for (int i = 0; i < 4; i++) if (!w[i][51]) return i;
        return 0;
    endfunction

    task automatic set_ways(input logic [3:0][52:0] w);
        for (int i = 0; i < 4; i++) bus.i_ways[i] = w[i];
    endtask

    task automatic scramble_ways();
        for (int i = 0; i < 4; i++) bus.i_ways[i] = {21'($urandom), $urandom};
    endtask

    task automatic run_fill(input string name, input logic [3:0] sel,
                            input logic [3:0][52:0] ways, input logic dirty,
                            input logic [17:0] tag, input logic [31:0] data,
                            input logic [11:0] idx, input logic [3:0] exp_we,
                            input bit exp_wb, input int wb_delay, input bit busy_req);
        int v;
        int done_before;
        v = 0;
        for (int i = 0; i < 4; i++) if (exp_we[i]) v = i;
        done_before = done_cnt;
        chk({name, " idle ready"}, 64'(bus.o_req_ready), 64'(1));
        bus.i_req_valid = 1'b1;
        bus.i_sel       = sel;
        bus.i_dirty     = dirty;
        bus.i_tag       = tag;
        bus.i_data      = data;
        bus.i_index     = idx;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.i_sel       = 4'($urandom);
        bus.i_dirty     = ~dirty;
        bus.i_tag       = ~tag;
        bus.i_data      = ~data;
        bus.i_index     = ~idx;
        set_ways(ways);
        chk({name, " select ready"}, 64'(bus.o_req_ready), 64'(0));
        chk({name, " select we"}, 64'(bus.o_we), 64'(0));
        @(posedge clk); #1;
        scramble_ways();
        if (exp_wb) begin
            chk({name, " wb_valid"}, 64'(bus.o_wb_valid), 64'(1));
            chk({name, " wb_tag"}, 64'(bus.o_wb_tag), 64'(ways[v][49:32]));
            chk({name, " wb_data"}, 64'(bus.o_wb_data), 64'(ways[v][31:0]));
            chk({name, " wb_index"}, 64'(bus.o_wb_index), 64'(idx));
            chk({name, " wb we"}, 64'(bus.o_we), 64'(0));
            for (int k = 0; k < wb_delay; k++) begin
                if (busy_req) bus.i_req_valid = 1'b1;
                @(posedge clk); #1;
                chk({name, " wb hold valid"}, 64'(bus.o_wb_valid), 64'(1));
                chk({name, " wb hold tag"}, 64'(bus.o_wb_tag), 64'(ways[v][49:32]));
                chk({name, " wb hold data"}, 64'(bus.o_wb_data), 64'(ways[v][31:0]));
                chk({name, " wb hold we"}, 64'(bus.o_we), 64'(0));
            end
            bus.i_wb_ready = 1'b1;
            @(posedge clk); #1;
            bus.i_wb_ready = 1'b0;
        end else begin
            chk({name, " no wb"}, 64'(bus.o_wb_valid), 64'(0));
        end
        bus.i_req_valid = 1'b0;
        chk({name, " we"}, 64'(bus.o_we), 64'(exp_we));
        chk({name, " done"}, 64'(bus.o_done), 64'(1));
        chk({name, " wdata"}, 64'(bus.o_wdata), 64'({2'b11, dirty, tag, data}));
        chk({name, " windex"}, 64'(bus.o_windex), 64'(idx));
        chk({name, " write wb_valid"}, 64'(bus.o_wb_valid), 64'(0));
        @(posedge clk); #1;
        chk({name, " ready again"}, 64'(bus.o_req_ready), 64'(1));
        chk({name, " we cleared"}, 64'(bus.o_we), 64'(0));
        chk({name, " done cleared"}, 64'(bus.o_done), 64'(0));
        chk({name, " done count"}, 64'(done_cnt - done_before), 64'(1));
    endtask

    // Accept a request and advance to the state after SELECT.
    task automatic start_fill(input logic [3:0] sel, input logic [3:0][52:0] ways);
        bus.i_req_valid = 1'b1;
        bus.i_sel       = sel;
        bus.i_dirty     = 1'b1;
        bus.i_tag       = 18'h1234;
        bus.i_data      = 32'hCAFEF00D;
        bus.i_index     = 12'hABC;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        set_ways(ways);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0][52:0] w;
        logic [3:0]       sel;
        int               vict;
        int               done_before;

        bus.i_req_valid = 1'b0;
        bus.i_index     = '0;
        bus.i_tag       = '0;
        bus.i_data      = '0;
        bus.i_dirty     = 1'b0;
        bus.i_sel       = '0;
        bus.i_wb_ready  = 1'b0;
        for (int i = 0; i < 4; i++) bus.i_ways[i] = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(bus.o_req_ready), 64'(1));
        chk("reset we", 64'(bus.o_we), 64'(0));
        chk("reset done", 64'(bus.o_done), 64'(0));
        chk("reset wb_valid", 64'(bus.o_wb_valid), 64'(0));
        chk("reset wb_tag", 64'(bus.o_wb_tag), 64'(0));
        chk("reset wb_data", 64'(bus.o_wb_data), 64'(0));
        chk("reset wb_index", 64'(bus.o_wb_index), 64'(0));
        chk("reset windex", 64'(bus.o_windex), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset ready", 64'(bus.o_req_ready), 64'(1));

        // name, sel, ways, dirty, exp_we, exp_wb, delay, busy
        vecs[0].name = "lru_pick";
        vecs[0].ways[0] = mk(1, 1, 0, 18'h00001, 32'h11111111);
        vecs[0].ways[1] = mk(1, 0, 0, 18'h00002, 32'h22222222);
        vecs[0].ways[2] = mk(1, 1, 0, 18'h00003, 32'h33333333);
        vecs[0].ways[3] = mk(1, 1, 0, 18'h00004, 32'h44444444);
        vecs[0].sel = 4'b0000; vecs[0].dirty = 1'b0; vecs[0].exp_we = 4'b0010;
        vecs[0].exp_wb = 1'b0; vecs[0].delay = 0; vecs[0].busy = 1'b0;

        vecs[1].name = "invalid_way2";
        vecs[1].ways[0] = mk(1, 0, 1, 18'h0AAAA, 32'h01010101);
        vecs[1].ways[1] = mk(1, 0, 1, 18'h0BBBB, 32'h02020202);
        vecs[1].ways[2] = mk(0, 0, 1, 18'h0CCCC, 32'h03030303);
        vecs[1].ways[3] = mk(1, 1, 1, 18'h0DDDD, 32'h04040404);
        vecs[1].sel = 4'b0000; vecs[1].dirty = 1'b1; vecs[1].exp_we = 4'b0100;
        vecs[1].exp_wb = 1'b0; vecs[1].delay = 0; vecs[1].busy = 1'b0;

        vecs[2].name = "forced_wb";
        vecs[2].ways[0] = mk(0, 0, 0, 18'h00000, 32'h00000000);
        vecs[2].ways[1] = mk(1, 1, 0, 18'h01111, 32'h55555555);
        vecs[2].ways[2] = mk(1, 0, 1, 18'h02222, 32'h66666666);
        vecs[2].ways[3] = mk(1, 1, 1, 18'h3ABCD, 32'hDEADBEEF);
        vecs[2].sel = 4'b1000; vecs[2].dirty = 1'b0; vecs[2].exp_we = 4'b1000;
        vecs[2].exp_wb = 1'b1; vecs[2].delay = 5; vecs[2].busy = 1'b0;

        vecs[3].name = "bad_sel";
        vecs[3].ways[0] = mk(0, 1, 1, 18'h12345, 32'h77777777);
        vecs[3].ways[1] = mk(1, 1, 1, 18'h23456, 32'h88888888);
        vecs[3].ways[2] = mk(1, 1, 1, 18'h34567, 32'h99999999);
        vecs[3].ways[3] = mk(1, 1, 1, 18'h01234, 32'hAAAAAAAA);
        vecs[3].sel = 4'b0110; vecs[3].dirty = 1'b1; vecs[3].exp_we = 4'b0001;
        vecs[3].exp_wb = 1'b0; vecs[3].delay = 0; vecs[3].busy = 1'b0;

        vecs[4].name = "all_invalid";
        for (int i = 0; i < 4; i++) vecs[4].ways[i] = mk(0, 0, 1, 18'h3FFFF, 32'hFFFFFFFF);
        vecs[4].sel = 4'b0000; vecs[4].dirty = 1'b0; vecs[4].exp_we = 4'b0001;
        vecs[4].exp_wb = 1'b0; vecs[4].delay = 0; vecs[4].busy = 1'b0;

        vecs[5].name = "all_lru_set";
        for (int i = 0; i < 4; i++) vecs[5].ways[i] = mk(1, 1, 0, 18'(i + 5), 32'(i * 3));
        vecs[5].sel = 4'b0000; vecs[5].dirty = 1'b1; vecs[5].exp_we = 4'b0001;
        vecs[5].exp_wb = 1'b0; vecs[5].delay = 0; vecs[5].busy = 1'b0;

        vecs[6].name = "busy_req_wb";
        for (int i = 0; i < 4; i++) vecs[6].ways[i] = mk(1, 1, 1, 18'(i + 9), 32'(i + 100));
        vecs[6].ways[0] = mk(1, 1, 1, 18'h2BEEF, 32'h0BADCAFE);
        vecs[6].sel = 4'b0000; vecs[6].dirty = 1'b0; vecs[6].exp_we = 4'b0001;
        vecs[6].exp_wb = 1'b1; vecs[6].delay = 3; vecs[6].busy = 1'b1;

        vecs[7].name = "forced_invalid_dirty";
        vecs[7].ways[0] = mk(0, 1, 1, 18'h15555, 32'h12345678);
        for (int i = 1; i < 4; i++) vecs[7].ways[i] = mk(1, 1, 1, 18'(i), 32'(i));
        vecs[7].sel = 4'b0001; vecs[7].dirty = 1'b1; vecs[7].exp_we = 4'b0001;
        vecs[7].exp_wb = 1'b0; vecs[7].delay = 0; vecs[7].busy = 1'b0;

        for (int n = 0; n < 8; n++) begin
            run_fill(vecs[n].name, vecs[n].sel, vecs[n].ways, vecs[n].dirty,
                     18'(32'h1F00 + n), 32'hA5A50000 + n, 12'(n * 37), vecs[n].exp_we,
                     vecs[n].exp_wb, vecs[n].delay, vecs[n].busy);
        end

        // Reset while waiting for writeback: fill is abandoned.
        w[0] = mk(1, 1, 1, 18'h11111, 32'h11111111);
        w[1] = mk(1, 1, 1, 18'h22222, 32'h22222222);
        w[2] = mk(1, 1, 1, 18'h33333, 32'h33333333);
        w[3] = mk(1, 1, 1, 18'h3ABCD, 32'hDEADBEEF);
        done_before = done_cnt;
        start_fill(4'b1000, w);
        chk("rst_wb wb_valid before", 64'(bus.o_wb_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_wb wb_valid drop", 64'(bus.o_wb_valid), 64'(0));
        chk("rst_wb ready in reset", 64'(bus.o_req_ready), 64'(1));
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_wb no we", 64'(bus.o_we), 64'(0));
            chk("rst_wb ready", 64'(bus.o_req_ready), 64'(1));
        end
        chk("rst_wb no done", 64'(done_cnt - done_before), 64'(0));

        // Reset during the write cycle cancels the strobe at once.
        w[1] = mk(0, 0, 0, 18'h0, 32'h0);
        start_fill(4'b0000, w);
        chk("rst_wr we before", 64'(bus.o_we), 64'(4'b0010));
        rst_n = 1'b0;
        #1;
        chk("rst_wr we drop", 64'(bus.o_we), 64'(0));
        chk("rst_wr done drop", 64'(bus.o_done), 64'(0));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_wr ready", 64'(bus.o_req_ready), 64'(1));
        chk("rst_wr windex cleared", 64'(bus.o_windex), 64'(0));

        // Randomized fills against the rule model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                w[i] = mk($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                          18'($urandom), $urandom);
            end
            case ($urandom_range(0, 2))
                0:       sel = 4'b0000;
                1:       sel = 4'b0001 << $urandom_range(0, 3);
                default: sel = 4'($urandom);
            endcase
            vict = model_victim(sel, w);
            run_fill("rand", sel, w, 1'($urandom), 18'($urandom), $urandom, 12'($urandom),
                     4'b0001 << vict, w[vict][52] & w[vict][50], $urandom_range(0, 3),
                     1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
